// File: rtl/rggen_register_access_sequencer.sv
// rggen_register_access_sequencer
//
// Host-side front end of the register block. Takes one host request at a
// time, broadcasts it to every register instance, and waits for the claiming
// register to signal ready. The captured status and read data are returned
// as a held response. The block answers with DECERR when no register claims
// the address, and with SLVERR when a claimed access stalls past
// TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0 turns the timeout off.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req_*, o_req_ready    host request channel
//   o_rsp_*, i_rsp_ready    host response channel (held until consumed)
//   o_register_*            broadcast access, qualified by o_register_valid
//   i_register_*            per-register active/ready/status/read data,
//                           slice i at [2i+:2] / [BUS_WIDTH*i+:BUS_WIDTH]
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the payload stays stable until that edge.
// This block never drops a raised valid on its own.
module rggen_register_access_sequencer #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
    input  logic                           i_req_write,
    input  logic [BUS_WIDTH-1:0]           i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_register_valid,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic                           o_register_write,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int LSB_WIDTH   = $clog2(BUS_WIDTH / 8);
    // A disabled timeout still gets a 1-bit counter so no signal has zero width.
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = {ADDRESS_WIDTH{1'b1}} << LSB_WIDTH;

    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                   state;
    state_e                   state_next;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     count_up;
    logic                     any_ready;
    logic                     any_active;
    logic                     timeout;
    logic [1:0]               ready_status;
    logic [BUS_WIDTH-1:0]     ready_data;
    logic                     load_rsp;
    logic [1:0]               status_next;
    logic [BUS_WIDTH-1:0]     data_next;

    // At most one register may be ready, so OR-ing the ready-masked slices
    // selects the responder without a priority encoder.
    always_comb begin
        ready_status = '0;
        ready_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (i_register_ready[i]) begin
                ready_status = ready_status | i_register_status[2*i+:2];
                ready_data   = ready_data | i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
            end
        end
    end

    assign any_ready  = |i_register_ready;
    assign any_active = |i_register_active;
    // Fires in the BUSY cycle that would be the TIMEOUT_CYCLES-th stalled one.
    assign timeout    = (TIMEOUT_CYCLES > 0) &&
                        (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next  = state;
        load_rsp    = 1'b0;
        count_up    = 1'b0;
        status_next = o_rsp_status;
        data_next   = o_rsp_read_data;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Ready wins over decode error and timeout in the same cycle.
                if (any_ready) begin
                    state_next  = RESP;
                    load_rsp    = 1'b1;
                    status_next = ready_status;
                    data_next   = o_register_write ? '0 : ready_data;
                end else if (!any_active) begin
                    state_next  = RESP;
                    load_rsp    = 1'b1;
                    status_next = STATUS_DECERR;
                    data_next   = '0;
                end else if (timeout) begin
                    state_next  = RESP;
                    load_rsp    = 1'b1;
                    status_next = STATUS_SLVERR;
                    data_next   = '0;
                end else begin
                    count_up = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                 <= IDLE;
            count                 <= '0;
            o_register_address    <= '0;
            o_register_write      <= 1'b0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_rsp_status          <= '0;
            o_rsp_read_data       <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && i_req_valid) begin
                o_register_address    <= i_req_address & ADDRESS_MASK;
                o_register_write      <= i_req_write;
                o_register_write_data <= i_req_write_data;
                o_register_strobe     <= i_req_strobe;
                count                 <= '0;
            end else if (count_up) begin
                count <= count + COUNT_WIDTH'(1);
            end
            if (load_rsp) begin
                o_rsp_status    <= status_next;
                o_rsp_read_data <= data_next;
            end
        end
    end

    // Handshake flags are decoded from state alone, so nothing on the
    // register side reaches the host side combinationally.
    assign o_req_ready      = (state == IDLE);
    assign o_register_valid = (state == BUSY);
    assign o_rsp_valid      = (state == RESP);

`ifdef RGGEN_ENABLE_SVA
    ast_onehot_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_register_valid |-> $onehot0(i_register_ready));
    ast_onehot_active: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_register_valid |-> $onehot0(i_register_active));
`endif

endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// Self-checking bench for rggen_register_access_sequencer with 4 registers
// and a 4-cycle timeout. Expected responses come from a transaction-level
// model: which register answers, on which BUSY cycle, and what it returns.
module tb_rggen_register_access_sequencer;

  localparam int AW      = 8;
  localparam int BW      = 32;
  localparam int NREG    = 4;
  localparam int TIMEOUT = 4;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_address;
  logic               req_write;
  logic [BW-1:0]      req_write_data;
  logic [BW/8-1:0]    req_strobe;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_status;
  logic [BW-1:0]      rsp_read_data;
  logic               register_valid;
  logic [AW-1:0]      register_address;
  logic               register_write;
  logic [BW-1:0]      register_write_data;
  logic [BW/8-1:0]    register_strobe;
  logic [NREG-1:0]    register_active;
  logic [NREG-1:0]    register_ready;
  logic [2*NREG-1:0]  register_status;
  logic [BW*NREG-1:0] register_read_data;

  int checks;
  int failures;

  rggen_register_access_sequencer #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .REGISTERS      (NREG),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_req_valid           (req_valid),
    .o_req_ready           (req_ready),
    .i_req_address         (req_address),
    .i_req_write           (req_write),
    .i_req_write_data      (req_write_data),
    .i_req_strobe          (req_strobe),
    .o_rsp_valid           (rsp_valid),
    .i_rsp_ready           (rsp_ready),
    .o_rsp_status          (rsp_status),
    .o_rsp_read_data       (rsp_read_data),
    .o_register_valid      (register_valid),
    .o_register_address    (register_address),
    .o_register_write      (register_write),
    .o_register_write_data (register_write_data),
    .o_register_strobe     (register_strobe),
    .i_register_active     (register_active),
    .i_register_ready      (register_ready),
    .i_register_status     (register_status),
    .i_register_read_data  (register_read_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Random content on every slice; the masking must ignore non-ready ones.
  task automatic scramble_register_side();
    register_active = '0;
    register_ready  = '0;
    register_status = 8'($urandom);
    for (int i = 0; i < NREG; i++) register_read_data[BW*i+:BW] = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_valid"}, 64'(register_valid), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_read_data), 64'd0);
    check({tag, "_reg_addr"}, 64'(register_address), 64'd0);
    check({tag, "_reg_write"}, 64'(register_write), 64'd0);
    check({tag, "_reg_wdata"}, 64'(register_write_data), 64'd0);
    check({tag, "_reg_strobe"}, 64'(register_strobe), 64'd0);
  endtask

  // One full transaction. target < 0 means no register claims the address;
  // ready_cycle is the BUSY cycle (1-based) in which the target is ready,
  // 0 means never. hold is the number of cycles the host stalls the response.
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                         input logic [BW/8-1:0] strb, input int target, input int ready_cycle,
                         input logic [1:0] st, input logic [BW-1:0] rd, input int hold);
    int            busy_n;
    logic [1:0]    exp_st;
    logic [BW-1:0] exp_rd;
    logic [AW-1:0] exp_addr;
    // reference model
    if (target < 0) begin
      busy_n = 1; exp_st = 2'b11; exp_rd = '0;
    end else if (ready_cycle >= 1 && ready_cycle <= TIMEOUT) begin
      busy_n = ready_cycle; exp_st = st; exp_rd = wr ? '0 : rd;
    end else begin
      busy_n = TIMEOUT; exp_st = 2'b10; exp_rd = '0;
    end
    exp_addr = addr & ~AW'(BW / 8 - 1);

    check("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_address = addr; req_write = wr;
    req_write_data = wdata; req_strobe = strb; rsp_ready = 1'b0;
    @(negedge clk);
    // New values on the request bus must not leak into the latched access.
    req_valid = 1'b0; req_address = AW'($urandom); req_write = ~wr;
    req_write_data = $urandom; req_strobe = 4'($urandom);
    for (int k = 1; k <= busy_n; k++) begin
      check("busy_reg_valid", 64'(register_valid), 64'd1);
      check("busy_req_ready", 64'(req_ready), 64'd0);
      check("busy_rsp_valid", 64'(rsp_valid), 64'd0);
      check("busy_reg_addr", 64'(register_address), 64'(exp_addr));
      check("busy_reg_write", 64'(register_write), 64'(wr));
      check("busy_reg_wdata", 64'(register_write_data), 64'(wdata));
      check("busy_reg_strobe", 64'(register_strobe), 64'(strb));
      scramble_register_side();
      if (target >= 0) begin
        register_active[target] = 1'b1;
        if (k == ready_cycle) begin
          register_ready[target] = 1'b1;
          register_status[2*target+:2] = st;
          register_read_data[BW*target+:BW] = rd;
        end
      end
      @(negedge clk);
    end
    scramble_register_side();
    check("resp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("resp_reg_valid", 64'(register_valid), 64'd0);
    check("resp_status", 64'(rsp_status), 64'(exp_st));
    check("resp_data", 64'(rsp_read_data), 64'(exp_rd));
    check("resp_reg_addr_held", 64'(register_address), 64'(exp_addr));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_address = AW'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_status", 64'(rsp_status), 64'(exp_st));
      check("hold_data", 64'(rsp_read_data), 64'(exp_rd));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_reg_valid", 64'(register_valid), 64'd0);
      check("hold_reg_addr", 64'(register_address), 64'(exp_addr));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(rsp_valid), 64'd0);
    check("done_req_ready", 64'(req_ready), 64'd1);
    check("done_reg_addr_held", 64'(register_address), 64'(exp_addr));
  endtask

  // directed steps, then randomized transactions
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_address = '0; req_write = 1'b0;
    req_write_data = '0; req_strobe = '0; rsp_ready = 1'b0;
    register_active = '0; register_ready = '0; register_status = '0;
    register_read_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 64'(req_ready), 64'd1);

    // write to register 2, ready on its first BUSY cycle
    run_txn(8'h08, 1'b1, 32'hDEADBEEF, 4'b0101, 2, 1, 2'b00, 32'hFFFF_FFFF, 0);
    // read register 1 with an unaligned address, ready on BUSY cycle 4
    run_txn(8'h05, 1'b0, 32'h0, 4'hF, 1, 4, 2'b00, 32'h12345678, 0);
    // unclaimed address
    run_txn(8'h40, 1'b0, 32'h0, 4'hF, -1, 0, 2'b00, 32'h0, 0);
    // active but never ready -> timeout
    run_txn(8'h0C, 1'b0, 32'h0, 4'hF, 0, 0, 2'b00, 32'hA5A5A5A5, 0);
    // ready in the expiry cycle wins
    run_txn(8'h0C, 1'b0, 32'h0, 4'hF, 3, 4, 2'b00, 32'h0BADF00D, 0);
    // register reports SLVERR itself; host stalls the response 5 cycles
    run_txn(8'h10, 1'b0, 32'h0, 4'hF, 0, 2, 2'b10, 32'hCAFEF00D, 5);

    // reset in the middle of BUSY drops the transaction
    req_valid = 1'b1; req_address = 8'h44; req_write = 1'b1;
    req_write_data = 32'h11223344; req_strobe = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    register_active = 4'b0010;
    check("midbusy_reg_valid", 64'(register_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midbusy_reset");
    check("midbusy_req_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    register_active = '0;
    @(negedge clk);
    run_txn(8'h04, 1'b0, 32'h0, 4'hF, 1, 2, 2'b00, 32'h55AA55AA, 1);

    for (int t = 0; t < 30; t++) begin
      run_txn(AW'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
              int'($urandom_range(0, NREG)) - 1, int'($urandom_range(0, TIMEOUT + 1)),
              2'($urandom_range(0, 1)) << 1, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
